seq_mul_unit: RTL
=================

Name: seq_mul_unit

Overview:
- Multi-cycle shift-add multiplier sitting between the register file read ports and its write port.
- Consumes readData1/readData2 as operands and the destination index from decode.
- Produces a single write-back beat (writeReg/writeData/writeControl) that drives the register file write port directly.
- Supports signed or unsigned operands and a low-word or high-word result.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits; one iteration per operand bit.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- op_hi  in  1  1 = write product[2W-1:W], 0 = write product[W-1:0]; captured with start.
- srcA  in  WIDTH  multiplicand (from readData1).
- srcB  in  WIDTH  multiplier (from readData2).
- destReg  in  REG_ADDR_W  destination index; captured with start.
- busy  out  1  high from the cycle after acceptance through the WB cycle inclusive.
- done  out  1  one-cycle pulse, coincident with writeControl.
- writeReg  out  REG_ADDR_W  destination index to the register file.
- writeData  out  WIDTH  result word.
- writeControl  out  1  register-file write enable.

Behaviour:
- Reset (rst low, async): state=IDLE. busy, done, writeControl, writeReg and writeData all 0. Iteration counter and accumulator 0.
- States: IDLE -> RUN -> SIGN -> WB -> IDLE.
- IDLE, start=1 at edge E0: capture op_signed, op_hi, destReg.
  - Signed mode: capture |srcA| and |srcB| as WIDTH-bit unsigned magnitudes (|-2^(W-1)| = 2^(W-1) fits), and record neg = sign(srcA) XOR sign(srcB).
  - Unsigned mode: capture raw operands, neg=0.
  - Clear the 2W-bit accumulator and the counter; go to RUN.
- RUN, WIDTH cycles (edges E1..E_WIDTH):
  - If multiplier LSB=1, add the multiplicand into the upper half of the accumulator, keeping the carry.
  - Shift {carry, accumulator, multiplier} right by 1 (standard shift-add).
  - Counter increments. Leave RUN when counter reaches WIDTH-1 at the edge.
- SIGN, 1 cycle: if neg, product = two's-complement negation of the 2W-bit accumulator. Register writeData (selected half), writeReg=destReg, writeControl=1, done=1.
- WB, 1 cycle:
  - writeControl=1 and done=1 are visible for exactly this cycle.
  - The register file captures at the next edge, E0+WIDTH+2 (34 cycles for WIDTH=32).
  - Then writeControl=0, done=0; return to IDLE.
- writeReg and writeData hold their last values outside WB. Only writeControl qualifies them.
- start while busy (RUN/SIGN/WB) is ignored and never queued. Earliest back-to-back acceptance is the first IDLE cycle after WB.
- Operand inputs may change after acceptance with no effect.
- rst asserted mid-operation: immediate abort to IDLE, all outputs 0, no write issued. No partial write is allowed even if rst falls during WB.
- No special case for destReg: every index, including 0, is written.

Decomposition:
- Shared package holds: WIDTH and REG_ADDR_W defaults; state encoding constants ST_IDLE, ST_RUN, ST_SIGN, ST_WB (2 bits); counter width clog2(WIDTH).
- One natural sub-module: seq_mul_negate, a combinational 2W-bit conditional two's-complement used by SIGN and also reused for operand magnitude capture.

Test Plan:
- Unsigned, srcA=7, srcB=6, op_hi=0, destReg=3 -> writeControl high for one cycle at start+33, writeReg=3, writeData=42, done coincident, busy low the cycle after.
- Signed, srcA=0xFFFFFFFD (-3), srcB=5, op_hi=0 -> writeData=0xFFFFFFF1. Same with op_hi=1 -> 0xFFFFFFFF.
- Signed, srcA=srcB=0x80000000, op_hi=1 -> 0x40000000; op_hi=0 -> 0x00000000. Unsigned op_hi=1 of same operands -> 0x40000000.
- Unsigned, srcA=srcB=0xFFFFFFFF, op_hi=1 -> 0xFFFFFFFE; op_hi=0 -> 0x00000001.
- start pulsed again at RUN cycle 10 with different operands -> ignored; exactly one write, carrying the first result. A new start in the first IDLE cycle is accepted.
- rst driven low at RUN cycle 20, released 2 cycles later -> all outputs 0 immediately, no writeControl pulse ever. A following request completes normally.

Source files
------------

// File: rtl/seq_mul_unit_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default sizes,
// FSM state encoding and the iteration-counter width helper.
package seq_mul_unit_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2,
        ST_WB   = 2'd3
    } mulState_t;

    // Counter must hold 0..w-1; keep at least one bit for degenerate widths.
    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cntWidth(DEF_WIDTH);

endpackage

// File: rtl/seq_mul_negate.sv
// Combinational conditional two's-complement of an N-bit value; used for
// operand magnitudes and for restoring the product sign.
module seq_mul_negate
    import seq_mul_unit_pkg::*;
#(
    parameter int N = 2 * DEF_WIDTH
) (
    input  logic [N-1:0] value,
    input  logic         negate,
    output logic [N-1:0] result
);

    assign result = negate ? (~value + N'(1)) : value;

endmodule

// File: rtl/seq_mul_unit.sv
// Multi-cycle shift-add multiplier feeding the register-file write port with
// a single write-back beat (signed/unsigned operands, low/high result word).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on acceptance
// ST_RUN  | WIDTH shift-add iterations on magnitudes
// ST_SIGN | apply product sign, register selected result word
// ST_WB   | writeControl/done asserted for the register-file capture
module seq_mul_unit
    import seq_mul_unit_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_signed,
    input  logic                  op_hi,
    input  logic [WIDTH-1:0]      srcA,
    input  logic [WIDTH-1:0]      srcB,
    input  logic [REG_ADDR_W-1:0] destReg,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [WIDTH-1:0]      writeData,
    output logic                  writeControl
);

    localparam int CNT_W = cntWidth(WIDTH);

    mulState_t             state;
    mulState_t             nextState;
    logic [CNT_W-1:0]      iterCnt;
    logic [WIDTH-1:0]      mcand;
    logic [2*WIDTH-1:0]    acc;
    logic                  neg;
    logic                  opHi;
    logic [REG_ADDR_W-1:0] dest;
    logic [WIDTH-1:0]      magA;
    logic [WIDTH-1:0]      magB;
    logic [2*WIDTH-1:0]    product;
    logic [WIDTH:0]        partial;
    logic                  lastIter;

    seq_mul_negate #(.N(WIDTH)) uNegA (
        .value  (srcA),
        .negate (op_signed & srcA[WIDTH-1]),
        .result (magA)
    );

    seq_mul_negate #(.N(WIDTH)) uNegB (
        .value  (srcB),
        .negate (op_signed & srcB[WIDTH-1]),
        .result (magB)
    );

    seq_mul_negate #(.N(2 * WIDTH)) uNegProd (
        .value  (acc),
        .negate (neg),
        .result (product)
    );

    // Upper half of acc is the running sum, lower half the remaining multiplier bits.
    assign partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (start) nextState = ST_RUN;
            ST_RUN:  if (lastIter) nextState = ST_SIGN;
            ST_SIGN: nextState = ST_WB;
            ST_WB:   nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iterCnt   <= '0;
            mcand     <= '0;
            acc       <= '0;
            neg       <= 1'b0;
            opHi      <= 1'b0;
            dest      <= '0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand   <= magA;
                        acc     <= {{WIDTH{1'b0}}, magB};
                        iterCnt <= '0;
                        neg     <= op_signed & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                        opHi    <= op_hi;
                        dest    <= destReg;
                    end
                end
                ST_RUN: begin
                    acc     <= {partial, acc[WIDTH-1:1]};
                    iterCnt <= iterCnt + CNT_W'(1);
                end
                ST_SIGN: begin
                    writeData <= opHi ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
                    writeReg  <= dest;
                end
                default: ;
            endcase
        end
    end

    // Decoded from state so an async reset during WB drops the write at once.
    assign busy         = (state != ST_IDLE);
    assign writeControl = (state == ST_WB);
    assign done         = (state == ST_WB);

endmodule
